// File: rtl/display_refresh_seq.sv
// Display refresh sequencer: walks an optional config block and then every digit,
// issuing one register write per step to a serial driver with an i_next handshake.
module display_refresh_seq #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_LIMIT = NUM_DIGITS - 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_stb,
  output logic                    o_busy,
  output logic                    o_ack,
  input  logic                    i_write_config,
  input  logic                    i_dirty_only,
  input  logic                    i_blank,
  input  logic [3:0]              i_intensity,
  input  logic [5*NUM_DIGITS-1:0] i_digits,
  output logic                    o_write,
  input  logic                    i_next,
  output logic [3:0]              o_addr,
  output logic [7:0]              o_data
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned DIG_W = 5 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_CFG   = IDX_W'(4);
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       BLANK_CODE = 8'h0F;

  typedef enum logic [1:0] {IDLE, CFG, DIGIT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DIG_W-1:0]            digits_q, digits_d;
  logic [3:0]                  intensity_q, intensity_d;
  logic                        blank_q, blank_d;
  logic                        dirty_q, dirty_d;
  logic [NUM_DIGITS-1:0][7:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       valid_q, valid_d;
  logic                        write_d, busy_d, ack_d;
  logic [3:0]                  addr_d;
  logic [7:0]                  data_d;

  logic [4:0]                  cur_digit;
  logic [7:0]                  cur_shadow;
  logic                        cur_valid;
  logic [7:0]                  digit_data;
  logic                        skip;
  logic [3:0]                  cfg_addr;
  logic [7:0]                  cfg_data;

  // Select the snapshot digit and shadow entry addressed by the current index
  always_comb begin
    cur_digit  = '0;
    cur_shadow = '0;
    cur_valid  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit  = digits_q[5*k +: 5];
        cur_shadow = shadow_q[k];
        cur_valid  = valid_q[k];
      end
    end
    digit_data = blank_q ? BLANK_CODE : {cur_digit[4], 3'b000, cur_digit[3:0]};
    skip       = dirty_q && cur_valid && (cur_shadow == digit_data);
  end

  // Config block register/value table indexed by step
  always_comb begin
    cfg_addr = 4'h9;
    cfg_data = 8'hFF;
    case (idx_q)
      IDX_W'(0): begin cfg_addr = 4'h9; cfg_data = 8'hFF; end
      IDX_W'(1): begin cfg_addr = 4'hA; cfg_data = {4'h0, intensity_q}; end
      IDX_W'(2): begin cfg_addr = 4'hB; cfg_data = {5'h00, 3'(SCAN_LIMIT)}; end
      IDX_W'(3): begin cfg_addr = 4'hC; cfg_data = 8'h01; end
      IDX_W'(4): begin cfg_addr = 4'hF; cfg_data = 8'h00; end
      default:   begin cfg_addr = 4'h9; cfg_data = 8'hFF; end
    endcase
  end

  // Next-state, handshake and shadow update logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    digits_d    = digits_q;
    intensity_d = intensity_q;
    blank_d     = blank_q;
    dirty_d     = dirty_q;
    shadow_d    = shadow_q;
    valid_d     = valid_q;
    write_d     = o_write;
    addr_d      = o_addr;
    data_d      = o_data;

    case (state_q)
      IDLE: begin
        if (i_stb) begin
          digits_d    = i_digits;
          intensity_d = i_intensity;
          blank_d     = i_blank;
          dirty_d     = i_dirty_only;
          idx_d       = '0;
          if (i_write_config) begin
            valid_d = '0;
            state_d = CFG;
          end else begin
            state_d = DIGIT;
          end
        end
      end
      CFG: begin
        if (!o_write) begin
          write_d = 1'b1;
          addr_d  = cfg_addr;
          data_d  = cfg_data;
        end else if (i_next) begin
          write_d = 1'b0;
          if (idx_q == LAST_CFG) begin
            idx_d   = '0;
            state_d = DIGIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DIGIT: begin
        if (!o_write) begin
          if (skip) begin
            if (idx_q == LAST_DIGIT) begin
              idx_d   = '0;
              state_d = DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            write_d = 1'b1;
            addr_d  = {1'b0, idx_q} + 4'd1;
            data_d  = digit_data;
          end
        end else if (i_next) begin
          write_d = 1'b0;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              shadow_d[k] = o_data;
              valid_d[k]  = 1'b1;
            end
          end
          if (idx_q == LAST_DIGIT) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CFG) || (state_d == DIGIT);
    ack_d  = (state_d == DONE);
  end

  // State, snapshot, shadow and registered outputs; reset wins over everything
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      digits_q    <= '0;
      intensity_q <= '0;
      blank_q     <= 1'b0;
      dirty_q     <= 1'b0;
      shadow_q    <= '0;
      valid_q     <= '0;
      o_write     <= 1'b0;
      o_addr      <= '0;
      o_data      <= '0;
      o_busy      <= 1'b0;
      o_ack       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      digits_q    <= digits_d;
      intensity_q <= intensity_d;
      blank_q     <= blank_d;
      dirty_q     <= dirty_d;
      shadow_q    <= shadow_d;
      valid_q     <= valid_d;
      o_write     <= write_d;
      o_addr      <= addr_d;
      o_data      <= data_d;
      o_busy      <= busy_d;
      o_ack       <= ack_d;
    end
  end

endmodule

// File: tb/tb_display_refresh_seq.sv
// Directed bench for display_refresh_seq: config, digit, dirty-only, blank/busy,
// mid-sequence reset, and 1/8-digit parameterisations.
module tb_display_refresh_seq;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_reset_n;
  logic        i_stb, i_write_config, i_dirty_only, i_blank, i_next;
  logic [3:0]  i_intensity;
  logic [29:0] i_digits;
  logic        o_busy, o_ack, o_write;
  logic [3:0]  o_addr;
  logic [7:0]  o_data;

  logic        stb1, busy1, ack1, write1, next1;
  logic [4:0]  digits1;
  logic [3:0]  addr1;
  logic [7:0]  data1;
  logic        stb8, busy8, ack8, write8, next8;
  logic [39:0] digits8;
  logic [3:0]  addr8;
  logic [7:0]  data8;

  assign next1 = write1;
  assign next8 = write8;

  int nvec = 0;
  int nerr = 0;
  int wr_cnt = 0, ack_cnt = 0;
  int wr1 = 0, ackc1 = 0, wr8 = 0, ackc8 = 0;
  logic [11:0] last1 = '0, last8 = '0;
  logic [11:0] log_q[$];

  display_refresh_seq #(.NUM_DIGITS(6)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_stb), .o_busy(o_busy), .o_ack(o_ack),
    .i_write_config(i_write_config), .i_dirty_only(i_dirty_only), .i_blank(i_blank),
    .i_intensity(i_intensity), .i_digits(i_digits), .o_write(o_write), .i_next(i_next),
    .o_addr(o_addr), .o_data(o_data));

  display_refresh_seq #(.NUM_DIGITS(1)) dut1 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(stb1), .o_busy(busy1), .o_ack(ack1),
    .i_write_config(1'b0), .i_dirty_only(1'b0), .i_blank(1'b0),
    .i_intensity(4'h0), .i_digits(digits1), .o_write(write1), .i_next(next1),
    .o_addr(addr1), .o_data(data1));

  display_refresh_seq #(.NUM_DIGITS(8)) dut8 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(stb8), .o_busy(busy8), .o_ack(ack8),
    .i_write_config(1'b0), .i_dirty_only(1'b0), .i_blank(1'b0),
    .i_intensity(4'h0), .i_digits(digits8), .o_write(write8), .i_next(next8),
    .o_addr(addr8), .o_data(data8));

  // Serial driver model: acknowledges 3 cycles after o_write rises, logging {addr,data}
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    i_next = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_write && !i_next) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          i_next = 1'b1;
          log_q.push_back({o_addr, o_data});
          wait_cnt = 0;
        end
      end else begin
        i_next = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitors: count write assertions and ack-high cycles on every DUT
  initial begin
    bit pw, pw1, pw8;
    pw = 0; pw1 = 0; pw8 = 0;
    forever begin
      @(negedge i_clk);
      if (o_write && !pw) wr_cnt++;
      if (o_ack) ack_cnt++;
      if (write1 && !pw1) begin wr1++; last1 = {addr1, data1}; end
      if (ack1) ackc1++;
      if (write8 && !pw8) begin wr8++; last8 = {addr8, data8}; end
      if (ack8) ackc8++;
      pw = o_write; pw1 = write1; pw8 = write8;
    end
  end

  task automatic clear_counts();
    wr_cnt = 0;
    ack_cnt = 0;
    log_q.delete();
  endtask

  task automatic pulse_stb(input bit cfg, input bit dirty, input bit blank,
                           input logic [3:0] inten, input logic [29:0] dig);
    @(negedge i_clk);
    while (o_busy || o_ack) @(negedge i_clk);
    i_stb = 1'b1; i_write_config = cfg; i_dirty_only = dirty; i_blank = blank;
    i_intensity = inten; i_digits = dig;
    @(posedge i_clk);
    #1;
    i_stb = 1'b0; i_write_config = 1'b0; i_dirty_only = 1'b0; i_blank = 1'b0;
    i_intensity = 4'h0; i_digits = '0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 1;
    while (!o_ack && cyc < 600) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    to = !o_ack;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_stb = 0; i_write_config = 0; i_dirty_only = 0; i_blank = 0;
    i_intensity = 4'h0; i_digits = '0;
    stb1 = 0; stb8 = 0; digits1 = '0; digits8 = '0;
    repeat (3) @(posedge i_clk);
    #1;
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", o_busy); end
    nvec++; if (o_ack !== 1'b0) begin nerr++; $display("FAIL rst_ack got %b want 0", o_ack); end
    nvec++; if (o_write !== 1'b0) begin nerr++; $display("FAIL rst_write got %b want 0", o_write); end
    nvec++; if (o_addr !== 4'h0) begin nerr++; $display("FAIL rst_addr got %h want 0", o_addr); end
    nvec++; if (o_data !== 8'h00) begin nerr++; $display("FAIL rst_data got %h want 00", o_data); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_config();
    logic [11:0] exp_w [11];
    logic [4:0]  dtab [6];
    logic [29:0] dig;
    int cyc;
    bit to;
    exp_w = '{12'h9FF, 12'hA07, 12'hB05, 12'hC01, 12'hF00,
              12'h101, 12'h282, 12'h303, 12'h484, 12'h505, 12'h686};
    dtab = '{5'h01, 5'h12, 5'h03, 5'h14, 5'h05, 5'h16};
    for (int k = 0; k < 6; k++) dig[5*k +: 5] = dtab[k];
    clear_counts();
    pulse_stb(1'b1, 1'b0, 1'b0, 4'h7, dig);
    nvec++; if (o_busy !== 1'b1) begin nerr++; $display("FAIL cfg_busy got %b want 1", o_busy); end
    wait_done(cyc, to);
    nvec++; if (to) begin nerr++; $display("FAIL cfg_timeout got timeout want ack"); end
    nvec++; if (log_q.size() != 11) begin nerr++; $display("FAIL cfg_count got %0d want 11", log_q.size()); end
    for (int i = 0; i < 11 && i < log_q.size(); i++) begin
      nvec++;
      if (log_q[i] !== exp_w[i]) begin
        nerr++; $display("FAIL cfg_write%0d got %h want %h", i, log_q[i], exp_w[i]);
      end
    end
    nvec++; if (ack_cnt != 1) begin nerr++; $display("FAIL cfg_ack got %0d want 1", ack_cnt); end
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL cfg_idle_busy got %b want 0", o_busy); end
  endtask

  task automatic test_digits();
    logic [29:0] dig;
    int cyc;
    bit to;
    for (int k = 0; k < 6; k++) dig[5*k +: 5] = 5'h13;
    clear_counts();
    pulse_stb(1'b0, 1'b0, 1'b0, 4'h0, dig);
    wait_done(cyc, to);
    nvec++; if (to) begin nerr++; $display("FAIL dig_timeout got timeout want ack"); end
    nvec++; if (log_q.size() != 6) begin nerr++; $display("FAIL dig_count got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      nvec++;
      if (log_q[i] !== {4'(i + 1), 8'h83}) begin
        nerr++; $display("FAIL dig_write%0d got %h want %h", i, log_q[i], {4'(i + 1), 8'h83});
      end
    end
  endtask

  task automatic test_dirty();
    logic [29:0] dig;
    int cyc;
    bit to;
    for (int k = 0; k < 6; k++) dig[5*k +: 5] = 5'h13;
    dig[10 +: 5] = 5'h05;
    clear_counts();
    pulse_stb(1'b0, 1'b1, 1'b0, 4'h0, dig);
    wait_done(cyc, to);
    nvec++; if (to) begin nerr++; $display("FAIL dirty_timeout got timeout want ack"); end
    nvec++; if (log_q.size() != 1) begin nerr++; $display("FAIL dirty_count got %0d want 1", log_q.size()); end
    nvec++;
    if (log_q.size() < 1 || log_q[0] !== 12'h305) begin
      nerr++; $display("FAIL dirty_write got %h want 305", (log_q.size() > 0) ? log_q[0] : 12'hxxx);
    end
    clear_counts();
    pulse_stb(1'b0, 1'b1, 1'b0, 4'h0, dig);
    wait_done(cyc, to);
    nvec++; if (wr_cnt != 0) begin nerr++; $display("FAIL clean_count got %0d want 0", wr_cnt); end
    nvec++; if (to || cyc != 7) begin nerr++; $display("FAIL clean_ack_cycle got %0d want 7", cyc); end
    nvec++; if (ack_cnt != 1) begin nerr++; $display("FAIL clean_ack got %0d want 1", ack_cnt); end
  endtask

  task automatic test_blank_busy();
    logic [29:0] dig;
    int cyc;
    bit to;
    for (int k = 0; k < 6; k++) dig[5*k +: 5] = 5'(k + 2);
    clear_counts();
    pulse_stb(1'b0, 1'b0, 1'b1, 4'h0, dig);
    repeat (6) @(negedge i_clk);
    i_stb = 1'b1; i_write_config = 1'b1;
    @(negedge i_clk);
    i_stb = 1'b0; i_write_config = 1'b0;
    #1;
    wait_done(cyc, to);
    repeat (20) @(posedge i_clk);
    #1;
    nvec++; if (to) begin nerr++; $display("FAIL blank_timeout got timeout want ack"); end
    nvec++; if (wr_cnt != 6) begin nerr++; $display("FAIL blank_count got %0d want 6", wr_cnt); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      nvec++;
      if (log_q[i] !== {4'(i + 1), 8'h0F}) begin
        nerr++; $display("FAIL blank_write%0d got %h want %h", i, log_q[i], {4'(i + 1), 8'h0F});
      end
    end
    nvec++; if (ack_cnt != 1) begin nerr++; $display("FAIL busy_ack got %0d want 1", ack_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] dig;
    int cyc;
    bit to;
    int guard;
    for (int k = 0; k < 6; k++) dig[5*k +: 5] = 5'h13;
    clear_counts();
    pulse_stb(1'b0, 1'b0, 1'b0, 4'h0, dig);
    guard = 0;
    while (!(log_q.size() == 2 && o_write) && guard < 200) begin
      @(posedge i_clk);
      #2;
      guard++;
    end
    nvec++; if (guard >= 200) begin nerr++; $display("FAIL mid_third_write got timeout want write"); end
    @(negedge i_clk);
    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    nvec++; if (o_write !== 1'b0) begin nerr++; $display("FAIL mid_write got %b want 0", o_write); end
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL mid_busy got %b want 0", o_busy); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    nvec++; if (ack_cnt != 0) begin nerr++; $display("FAIL mid_ack got %0d want 0", ack_cnt); end
    clear_counts();
    pulse_stb(1'b0, 1'b1, 1'b0, 4'h0, dig);
    wait_done(cyc, to);
    nvec++; if (to) begin nerr++; $display("FAIL post_rst_timeout got timeout want ack"); end
    nvec++; if (wr_cnt != 6) begin nerr++; $display("FAIL post_rst_count got %0d want 6", wr_cnt); end
  endtask

  task automatic test_params();
    int guard;
    wr1 = 0; ackc1 = 0; wr8 = 0; ackc8 = 0;
    @(negedge i_clk);
    digits1 = 5'h19;
    for (int k = 0; k < 8; k++) digits8[5*k +: 5] = 5'(k);
    stb1 = 1'b1; stb8 = 1'b1;
    @(negedge i_clk);
    stb1 = 1'b0; stb8 = 1'b0;
    guard = 0;
    while ((ackc1 == 0 || ackc8 == 0) && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    repeat (3) @(negedge i_clk);
    nvec++; if (guard >= 200) begin nerr++; $display("FAIL param_timeout got timeout want ack"); end
    nvec++; if (wr1 != 1) begin nerr++; $display("FAIL n1_count got %0d want 1", wr1); end
    nvec++; if (last1 !== 12'h189) begin nerr++; $display("FAIL n1_write got %h want 189", last1); end
    nvec++; if (wr8 != 8) begin nerr++; $display("FAIL n8_count got %0d want 8", wr8); end
    nvec++; if (last8 !== 12'h807) begin nerr++; $display("FAIL n8_last got %h want 807", last8); end
    nvec++; if (ackc1 != 1 || ackc8 != 1) begin
      nerr++; $display("FAIL param_ack got %0d/%0d want 1/1", ackc1, ackc8);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_digits();
    test_dirty();
    test_blank_busy();
    test_reset_mid();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/display_refresh_seq.md
DISPLAY_REFRESH_SEQ -- requirements
Module: display_refresh_seq

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of display digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_LIMIT, default NUM_DIGITS-1, value written to the scan-limit register (3 bits).
REQ-003 SHALL have ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous reset, active-low.
- i_stb  in  1  request one refresh sequence.
- o_busy  out  1  sequence in progress.
- o_ack  out  1  one-cycle pulse at sequence end.
- i_write_config  in  1  at i_stb: prepend the config block.
- i_dirty_only  in  1  at i_stb: skip digits unchanged since the last write.
- i_blank  in  1  at i_stb: write the blank code to every digit.
- i_intensity  in  4  intensity register value.
- i_digits  in  5*NUM_DIGITS  digit k at [5k+4:5k] = {dp, bcd[3:0]}; k=0 is the MSD.
- o_write  out  1  register write request to the serial driver.
- i_next  in  1  driver acknowledge, one-cycle pulse.
- o_addr  out  4  register address.
- o_data  out  8  register data.

Function
REQ-004 SHALL accept i_stb only when o_busy=0 and o_ack=0; i_stb at any other time SHALL be ignored.
REQ-005 SHALL, on acceptance, snapshot i_digits, i_intensity, i_blank, i_dirty_only and i_write_config; later input changes SHALL NOT affect the running sequence.
REQ-006 SHALL use FSM states IDLE, CFG, DIGIT, DONE.
REQ-007 SHALL transition on acceptance from IDLE to CFG if i_write_config=1, else to DIGIT.
REQ-008 SHALL issue five config writes in CFG, in order:
- (0x9, 0xFF)
- (0xA, {4'h0, intensity})
- (0xB, {5'h0, SCAN_LIMIT})
- (0xC, 0x01)
- (0xF, 0x00)
Then CFG SHALL go to DIGIT.
REQ-009 SHALL step the digit index k from 0 to NUM_DIGITS-1 in DIGIT and write (addr k+1, data {dp, 3'b000, bcd}); with blank set, data SHALL be 0x0F.
REQ-010 SHALL, in dirty-only mode, skip digit k without asserting o_write when shadow k is valid and equals the data to be written; each skip SHALL take exactly one cycle.
REQ-011 SHALL keep a per-digit shadow of the last data acknowledged by i_next plus a valid bit, updating both on every digit write ack.
REQ-012 SHALL clear all shadow valid bits on reset and on every accepted sequence with i_write_config=1.
REQ-013 SHALL, in the handshake:
- assert o_write the cycle after the sequence step is entered;
- hold o_write, o_addr and o_data stable until a cycle with i_next=1;
- drop o_write the next cycle and advance.
i_next while o_write=0 SHALL be ignored.
REQ-014 SHALL enter DONE after the last digit (written or skipped), assert o_ack for exactly one cycle there, then return to IDLE.
REQ-015 SHALL assert o_busy in CFG and DIGIT, and deassert it in IDLE and DONE.
REQ-016 SHALL reach DONE and pulse o_ack even when every digit is skipped, with zero writes issued.
REQ-017 SHALL issue exactly 5 + NUM_DIGITS writes for a full sequence with config and no skips.

Reset
REQ-018 SHALL, while i_reset_n=0 at a clock edge:
- go to IDLE;
- drive o_busy=0, o_ack=0, o_write=0, o_addr=0, o_data=0;
- clear the digit index and all shadow valid bits.
REQ-019 SHALL treat reset as taking priority over all other inputs; reset mid-sequence SHALL abort with no o_ack, and a pending i_next SHALL be discarded.

Verification
REQ-020 SHALL have a bench covering a config sequence: NUM_DIGITS=6, i_write_config=1, i_intensity=7, driver acks 3 cycles after each o_write -> 11 writes:
- 9/FF, A/07, B/05, C/01, F/00;
- digits at addr 1..6;
- one o_ack pulse.
REQ-021 SHALL have a bench covering the digit path: i_digits all {dp=1, bcd=3}, no config -> 6 writes at addr 1..6, data 0x83 each.
REQ-022 SHALL have a bench covering dirty-only skipping: repeat REQ-021 with i_dirty_only=1, digit 2 changed to bcd=5 -> exactly one write (addr 3, 0x05); then one more stb with no change -> zero writes, o_ack pulse 7 cycles after acceptance.
REQ-023 SHALL have a bench covering blank and busy: i_blank=1 -> all digit data 0x0F; i_stb pulsed while o_busy=1 -> no restart, no extra writes.
REQ-024 SHALL have a bench covering reset and parameters:
- reset asserted during the 3rd write -> next cycle o_write=0, o_busy=0, no o_ack;
- subsequent dirty-only stb writes all digits;
- NUM_DIGITS=1 and NUM_DIGITS=8 runs produce 1 and 8 digit writes.
